// File: rtl/hdmi_cfg_sequencer.sv
// Avalon-MM write master that programs the HDMI pattern/sync generator.
// On start it optionally reloads the 256-entry gamma LUT with gamma held off,
// then commits pattern mode and gamma enable on a vsync rising edge (or on
// timeout) so that visible changes land between frames.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for start; cfg_* latched into shadows on accept
// S_WR_GOFF  | writing addr 1 = 0, gamma off while the LUT is rewritten
// S_WR_LADDR | writing addr 2 = LUT index
// S_WR_LDATA | writing addr 3 = f(index)
// S_WAIT_VS  | waiting for a fresh vsync rising edge or the timeout
// S_WR_MODE  | writing addr 0 = pattern mode
// S_WR_GEN   | writing addr 1 = gamma enable
// S_DONE     | one-cycle done pulse, busy drops on the next cycle
module hdmi_cfg_sequencer #(
  parameter int unsigned VS_TIMEOUT = 2000000,
  parameter bit          VS_SYNC_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  cfg_mode,
  input  logic        cfg_gamma_en,
  input  logic        cfg_load_lut,
  input  logic [1:0]  cfg_curve,
  input  logic        hdmi_vs,
  output logic [2:0]  avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        vs_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_GOFF, S_WR_LADDR, S_WR_LDATA,
    S_WAIT_VS, S_WR_MODE, S_WR_GEN, S_DONE
  } state_t;

  localparam int unsigned   TW      = $clog2(VS_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(VS_TIMEOUT - 1);

  state_t        state_q;
  logic [2:0]    mode_q;
  logic          gamma_en_q;
  logic [1:0]    curve_q;
  logic [7:0]    idx_q;
  logic [TW-1:0] to_cnt_q;
  logic          vs_d_q;
  logic [2:0]    addr_q;
  logic          write_q;
  logic [31:0]   wdata_q;
  logic          busy_q;
  logic          done_q;
  logic          vs_timeout_q;

  logic vs_rise;
  logic wr_done;

  // Gamma curve value for one LUT index.
  function automatic logic [7:0] curve_f(input logic [1:0] c, input logic [7:0] i);
    logic [15:0] sq;
    sq = {8'd0, i} * {8'd0, i};
    case (c)
      2'd0:    curve_f = i;
      2'd1:    curve_f = ~i;
      2'd2:    curve_f = sq[15:8];
      default: curve_f = {8{i[7]}};
    endcase
  endfunction

  assign vs_rise = hdmi_vs & ~vs_d_q;
  // write_q is always high in the WR_* states, so only the stall matters
  assign wr_done = ~avm_waitrequest;

  // Vsync delayed copy, sampled in every state so it is valid on WAIT_VS entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vs_d_q <= 1'b0;
    else          vs_d_q <= hdmi_vs;
  end

  // Sequencer FSM with registered bus and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      gamma_en_q   <= 1'b0;
      curve_q      <= '0;
      idx_q        <= '0;
      to_cnt_q     <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vs_timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q       <= cfg_mode;
            gamma_en_q   <= cfg_gamma_en;
            curve_q      <= cfg_curve;
            busy_q       <= 1'b1;
            vs_timeout_q <= 1'b0;
            to_cnt_q     <= '0;
            if (cfg_load_lut) begin
              state_q <= S_WR_GOFF;
              write_q <= 1'b1;
              addr_q  <= 3'd1;
              wdata_q <= '0;
            end else begin
              state_q <= S_WAIT_VS;
            end
          end
        end
        S_WR_GOFF: begin
          if (wr_done) begin
            idx_q   <= '0;
            state_q <= S_WR_LADDR;
            addr_q  <= 3'd2;
            wdata_q <= '0;
          end
        end
        S_WR_LADDR: begin
          if (wr_done) begin
            state_q <= S_WR_LDATA;
            addr_q  <= 3'd3;
            wdata_q <= {24'd0, curve_f(curve_q, idx_q)};
          end
        end
        S_WR_LDATA: begin
          if (wr_done) begin
            if (idx_q == 8'hFF) begin
              state_q  <= S_WAIT_VS;
              write_q  <= 1'b0;
              addr_q   <= '0;
              wdata_q  <= '0;
              to_cnt_q <= '0;
            end else begin
              idx_q   <= idx_q + 8'd1;
              state_q <= S_WR_LADDR;
              addr_q  <= 3'd2;
              wdata_q <= {24'd0, idx_q + 8'd1};
            end
          end
        end
        S_WAIT_VS: begin
          // an edge on the last timeout cycle wins, leaving vs_timeout clear
          if (!VS_SYNC_EN || vs_rise || (to_cnt_q == TO_LAST)) begin
            if (VS_SYNC_EN && !vs_rise) vs_timeout_q <= 1'b1;
            state_q <= S_WR_MODE;
            write_q <= 1'b1;
            addr_q  <= 3'd0;
            wdata_q <= {29'd0, mode_q};
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        S_WR_MODE: begin
          if (wr_done) begin
            state_q <= S_WR_GEN;
            addr_q  <= 3'd1;
            wdata_q <= {31'd0, gamma_en_q};
          end
        end
        S_WR_GEN: begin
          if (wr_done) begin
            state_q <= S_DONE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign avm_address   = addr_q;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign vs_timeout    = vs_timeout_q;

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Bench for hdmi_cfg_sequencer. Instance u_a (no vsync wait) is checked by a
// scoreboard fed from a reference model of the write sequence; u_b and u_c
// (vsync wait, long and short timeout) get directed cycle-accurate checks.
module tb_hdmi_cfg_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [2:0]  cfg_mode = '0;
  logic        cfg_gamma_en = 1'b0, cfg_load_lut = 1'b0;
  logic [1:0]  cfg_curve = '0;
  logic        hdmi_vs = 1'b0;
  logic        wreq_a = 1'b0;
  logic        wreq_0 = 1'b0;
  logic        stall_en = 1'b0;

  logic [2:0]  addr_a, addr_b, addr_c;
  logic        write_a, write_b, write_c;
  logic [31:0] data_a, data_b, data_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        vto_a, vto_b, vto_c;

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];
  int wr_cnt = 0;
  int done_cnt = 0;
  int lut_obs[256];
  int lut_ptr = 0;

  hdmi_cfg_sequencer #(.VS_SYNC_EN(1'b0)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .cfg_mode(cfg_mode),
    .cfg_gamma_en(cfg_gamma_en), .cfg_load_lut(cfg_load_lut), .cfg_curve(cfg_curve),
    .hdmi_vs(hdmi_vs), .avm_address(addr_a), .avm_write(write_a),
    .avm_writedata(data_a), .avm_waitrequest(wreq_a), .busy(busy_a),
    .done(done_a), .vs_timeout(vto_a));

  hdmi_cfg_sequencer #(.VS_SYNC_EN(1'b1), .VS_TIMEOUT(1000)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .cfg_mode(cfg_mode),
    .cfg_gamma_en(cfg_gamma_en), .cfg_load_lut(cfg_load_lut), .cfg_curve(cfg_curve),
    .hdmi_vs(hdmi_vs), .avm_address(addr_b), .avm_write(write_b),
    .avm_writedata(data_b), .avm_waitrequest(wreq_0), .busy(busy_b),
    .done(done_b), .vs_timeout(vto_b));

  hdmi_cfg_sequencer #(.VS_SYNC_EN(1'b1), .VS_TIMEOUT(50)) u_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .cfg_mode(cfg_mode),
    .cfg_gamma_en(cfg_gamma_en), .cfg_load_lut(cfg_load_lut), .cfg_curve(cfg_curve),
    .hdmi_vs(hdmi_vs), .avm_address(addr_c), .avm_write(write_c),
    .avm_writedata(data_c), .avm_waitrequest(wreq_0), .busy(busy_c),
    .done(done_c), .vs_timeout(vto_c));

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference gamma curves straight from the arithmetic definition.
  function automatic int ref_f(input int c, input int i);
    case (c)
      0:       return i;
      1:       return 255 - i;
      2:       return (i * i) / 256;
      default: return (i >= 128) ? 255 : 0;
    endcase
  endfunction

  task automatic push_seq(input bit load, input int curve, input int mode, input int gen);
    if (load) begin
      exp_q.push_back({3'd1, 32'd0});
      for (int i = 0; i < 256; i++) begin
        exp_q.push_back({3'd2, 32'(i)});
        exp_q.push_back({3'd3, 32'(ref_f(curve, i))});
      end
    end
    exp_q.push_back({3'd0, 32'(mode)});
    exp_q.push_back({3'd1, 32'(gen)});
  endtask

  // Waitrequest driver for u_a, about 30 percent stalls when enabled.
  initial forever begin
    @(posedge clk);
    #1;
    wreq_a = stall_en ? ($urandom_range(0, 99) < 30) : 1'b0;
  end

  // Monitor for u_a: stall stability, completed-write scoreboard, done pulses.
  initial begin
    logic        stall_pend;
    logic [2:0]  paddr;
    logic [31:0] pdata;
    logic [34:0] e;
    stall_pend = 1'b0;
    paddr = '0;
    pdata = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (stall_pend)
          chk("stall_hold", {write_a, addr_a, data_a}, {1'b1, paddr, pdata});
        if (write_a && !wreq_a) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {addr_a, data_a}, 35'h7_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("write_seq", {addr_a, data_a}, e);
          end
          if (addr_a == 3'd2) lut_ptr = int'(data_a[7:0]);
          if (addr_a == 3'd3) lut_obs[lut_ptr] = int'(data_a[7:0]);
        end
        stall_pend = write_a && wreq_a;
        paddr = addr_a;
        pdata = data_a;
        if (done_a) begin
          done_cnt++;
          chk("done_after_all_writes", exp_q.size(), 0);
        end
      end else begin
        stall_pend = 1'b0;
      end
    end
  end

  task automatic wait_done_a(input int bound);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", (done_cnt != base), 1);
  endtask

  task automatic pulse(input int which);
    @(posedge clk);
    #1;
    if (which == 0) start_a = 1'b1;
    else if (which == 1) start_b = 1'b1;
    else start_c = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic run_a(input bit load, input int curve, input int mode, input int gen,
                       input bit poke_busy);
    int wbase = wr_cnt;
    int dbase = done_cnt;
    cfg_load_lut = load;
    cfg_curve    = 2'(curve);
    cfg_mode     = 3'(mode);
    cfg_gamma_en = gen[0];
    push_seq(load, curve, mode, gen);
    pulse(0);
    cfg_mode     = 3'($urandom);
    cfg_gamma_en = 1'($urandom);
    cfg_curve    = 2'($urandom);
    cfg_load_lut = 1'($urandom);
    if (poke_busy) begin
      repeat (20) @(posedge clk);
      #1;
      cfg_load_lut = 1'b1;
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
    end
    wait_done_a(load ? 6000 : 50);
    repeat (20) @(negedge clk);
    chk("write_count", wr_cnt - wbase, load ? 515 : 2);
    chk("done_count", done_cnt - dbase, 1);
    chk("queue_empty", exp_q.size(), 0);
    if (load)
      for (int i = 0; i < 256; i++) chk("lut_model", lut_obs[i], ref_f(curve, i));
  endtask

  initial begin
    int base;
    int nb;
    int found;
    logic [2:0] m;
    logic g;

    // reset held with random inputs
    stall_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      start_a = 1'($urandom); start_b = 1'($urandom); start_c = 1'($urandom);
      cfg_mode = 3'($urandom); cfg_gamma_en = 1'($urandom);
      cfg_load_lut = 1'($urandom); cfg_curve = 2'($urandom); hdmi_vs = 1'($urandom);
      @(negedge clk);
      chk("reset_outputs", {write_a, busy_a, done_a, vto_a, write_b, busy_b, done_b, vto_b,
                            write_c, busy_c, done_c, vto_c}, 0);
    end
    stall_en = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; hdmi_vs = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    base = wr_cnt;
    repeat (1000) @(negedge clk);
    chk("idle_no_writes", wr_cnt - base, 0);
    chk("idle_not_busy", {busy_a, busy_b, busy_c}, 0);

    // no-LUT latency: mode write at cycle 2, gamma at 3, done at 4
    cfg_load_lut = 1'b0; cfg_mode = 3'd5; cfg_gamma_en = 1'b0;
    push_seq(1'b0, 0, 5, 0);
    pulse(0);
    @(negedge clk); chk("lat_c1", {busy_a, write_a}, 2'b10);
    @(negedge clk); chk("lat_c2_mode", {write_a, addr_a, data_a}, {1'b1, 3'd0, 32'd5});
    @(negedge clk); chk("lat_c3_gen", {write_a, addr_a, data_a}, {1'b1, 3'd1, 32'd0});
    @(negedge clk); chk("lat_c4_done", {done_a, busy_a, write_a}, 3'b110);
    @(negedge clk); chk("lat_c5_idle", {busy_a, done_a}, 2'b00);

    // LUT loads, zero wait
    run_a(1'b1, 0, 3, 1, 1'b0);
    run_a(1'b1, 2, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 1'b0);
    run_a(1'b1, 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 1'b0);

    // random stalls, plus a start pulse while busy
    stall_en = 1'b1;
    run_a(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 1)), 1'b1);
    run_a(1'b1, 3, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 1'b0);
    run_a(1'b0, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 1'b0);
    stall_en = 1'b0;
    repeat (3) @(negedge clk);

    // vsync commit: vs high on entry, falls after 100, rises after 200 more
    m = 3'($urandom); g = 1'($urandom);
    cfg_load_lut = 1'b0; cfg_mode = m; cfg_gamma_en = g;
    hdmi_vs = 1'b1;
    repeat (3) @(posedge clk);
    pulse(1);
    nb = 0;
    for (int k = 0; k < 300; k++) begin
      if (k == 100) hdmi_vs = 1'b0;
      @(negedge clk);
      if (write_b) nb++;
      @(posedge clk);
      #1;
    end
    hdmi_vs = 1'b1;
    @(negedge clk); chk("vs_edge_cycle_no_write", write_b, 1'b0);
    @(negedge clk); chk("vs_mode_write", {write_b, addr_b, data_b}, {1'b1, 3'd0, 29'd0, m});
    @(negedge clk); chk("vs_gen_write", {write_b, addr_b, data_b}, {1'b1, 3'd1, 31'd0, g});
    @(negedge clk); chk("vs_done", {done_b, vto_b}, 2'b10);
    chk("vs_no_early_write", nb, 0);
    hdmi_vs = 1'b0;

    // timeout with vs low: 50 cycles in WAIT_VS, commit with vs_timeout set
    m = 3'($urandom); g = 1'($urandom);
    cfg_mode = m; cfg_gamma_en = g;
    repeat (3) @(posedge clk);
    pulse(2);
    nb = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (write_c) nb++;
      if (k == 50) chk("to_not_yet", vto_c, 1'b0);
    end
    @(negedge clk); chk("to_mode_write", {write_c, addr_c, data_c}, {1'b1, 3'd0, 29'd0, m});
    chk("to_flag_set", vto_c, 1'b1);
    @(negedge clk); chk("to_gen_write", {write_c, addr_c, data_c}, {1'b1, 3'd1, 31'd0, g});
    @(negedge clk); chk("to_done", {done_c, vto_c}, 2'b11);
    chk("to_no_early_write", nb, 0);

    // edge on the final timeout cycle counts as the edge
    pulse(2);
    @(negedge clk); chk("to_flag_cleared", {busy_c, vto_c}, 2'b10);
    repeat (49) @(posedge clk);
    #1;
    hdmi_vs = 1'b1;
    @(negedge clk); chk("edge_tie_no_write", write_c, 1'b0);
    @(negedge clk); chk("edge_tie_commit", {write_c, addr_c, vto_c}, {1'b1, 3'd0, 1'b0});
    repeat (3) @(negedge clk);
    chk("edge_tie_idle", {busy_c, vto_c}, 2'b00);
    hdmi_vs = 1'b0;

    // reset mid-LUT at index 100, then a clean full rerun
    cfg_load_lut = 1'b1; cfg_curve = 2'd0; cfg_mode = 3'd1; cfg_gamma_en = 1'b1;
    push_seq(1'b1, 0, 1, 1);
    pulse(0);
    found = 0;
    for (int k = 0; k < 1000 && found == 0; k++) begin
      @(negedge clk);
      if (write_a && addr_a == 3'd2 && data_a == 32'd100) found = 1;
    end
    chk("reached_index_100", found, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_async_outputs", {write_a, busy_a, done_a, vto_a, addr_a, data_a}, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_a(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 1)), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
